// File: rtl/instr_fetch_stage_if.sv
// Instruction-fetch stage bus: decode-side stall/redirect controls, the
// program-load write port, and the IF/ID register outputs.
//   master : drives stall, redirects and program load; receives IF/ID
//   slave  : the fetch stage itself
interface instr_fetch_stage_if #(
  parameter int IMEM_AW = 8
);
  logic               stall;
  logic               branch_taken;
  logic [31:0]        branch_offset;
  logic               jump;
  logic [25:0]        jump_target;
  logic               imem_wr_en;
  logic [IMEM_AW-1:0] imem_wr_addr;
  logic [31:0]        imem_wr_data;
  logic [31:0]        machineCode;
  logic [31:0]        PC_out;
  logic [31:0]        PC_plus4;
  logic               instr_valid;

  modport master (
    output stall, branch_taken, branch_offset, jump, jump_target,
           imem_wr_en, imem_wr_addr, imem_wr_data,
    input  machineCode, PC_out, PC_plus4, instr_valid
  );

  modport slave (
    input  stall, branch_taken, branch_offset, jump, jump_target,
           imem_wr_en, imem_wr_addr, imem_wr_data,
    output machineCode, PC_out, PC_plus4, instr_valid
  );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction-fetch stage: PC, loadable word-addressed instruction memory
// and the IF/ID register. Handles decode stalls and branch/jump redirects
// with a single flushed slot.
// Ports:
//   SYS_clk    system clock, rising edge
//   SYS_reset  asynchronous active-high reset
//   bus        instr_fetch_stage_if.slave (controls, program load, IF/ID outputs)
module instr_fetch_stage #(
  parameter int          IMEM_AW  = 8,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                  SYS_clk,
  input logic                  SYS_reset,
  instr_fetch_stage_if.slave   bus
);

  logic [31:0] imem [2**IMEM_AW];

  logic [31:0] pc;
  logic [31:0] machine_code_q;
  logic [31:0] pc_out_q;
  logic [31:0] pc_plus4_q;
  logic        valid_q;

  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] fetch_word;

  // Redirects refer to the instruction in IF/ID, so a flushed slot
  // (valid_q=0) can never cause one.
  assign redirect = valid_q && (bus.jump || bus.branch_taken);

  always_comb begin
    if (bus.jump)
      redirect_target = {pc_plus4_q[31:28], bus.jump_target, 2'b00};
    else
      redirect_target = pc_plus4_q + (bus.branch_offset << 2);
  end

  // Upper PC bits alias onto the memory depth.
  assign fetch_word = imem[pc[IMEM_AW+1:2]];

  // Memory contents survive reset, hence no reset branch here.
  always_ff @(posedge SYS_clk) begin
    if (bus.imem_wr_en)
      imem[bus.imem_wr_addr] <= bus.imem_wr_data;
  end

  always_ff @(posedge SYS_clk or posedge SYS_reset) begin
    if (SYS_reset) begin
      pc             <= RESET_PC;
      machine_code_q <= 32'h0;
      pc_out_q       <= 32'h0;
      pc_plus4_q     <= 32'h4;
      valid_q        <= 1'b0;
    end else if (redirect) begin
      // Redirect wins over stall; PC_out/PC_plus4 keep the redirecting
      // instruction's values.
      pc             <= redirect_target;
      machine_code_q <= 32'h0;
      valid_q        <= 1'b0;
    end else if (!bus.stall) begin
      pc             <= pc + 32'd4;
      machine_code_q <= fetch_word;
      pc_out_q       <= pc;
      pc_plus4_q     <= pc + 32'd4;
      valid_q        <= 1'b1;
    end
  end

  assign bus.machineCode = machine_code_q;
  assign bus.PC_out      = pc_out_q;
  assign bus.PC_plus4    = pc_plus4_q;
  assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

  localparam int AW = 8;
  localparam int DEPTH = 256;

  logic SYS_clk = 1'b0;
  logic SYS_reset;

  instr_fetch_stage_if #(.IMEM_AW(AW)) bus ();

  instr_fetch_stage #(.IMEM_AW(AW), .RESET_PC(32'h0)) dut (
    .SYS_clk   (SYS_clk),
    .SYS_reset (SYS_reset),
    .bus       (bus)
  );

  always #5 SYS_clk = ~SYS_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of the stage.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] m_pc, m_mc, m_pcout, m_p4;
  logic        m_valid;

  localparam logic [31:0] W_A = 32'hA000_000A;
  localparam logic [31:0] W_B = 32'hB000_000B;
  localparam logic [31:0] W_C = 32'hC000_000C;
  localparam logic [31:0] W_D = 32'hD000_000D;
  localparam logic [31:0] W_NEW = 32'h1234_5678;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_mc = 32'h0; m_pcout = 32'h0; m_p4 = 32'h4; m_valid = 1'b0;
  endtask

  // One clock edge of the architectural behaviour, using the inputs
  // presented at that edge.
  task automatic model_step();
    logic [31:0] target;
    logic [31:0] old_word;
    old_word = mem_m[(m_pc / 4) % DEPTH];
    if (m_valid && (bus.jump || bus.branch_taken)) begin
      if (bus.jump)
        target = (m_p4 & 32'hF000_0000) + {4'h0, bus.jump_target, 2'b00};
      else
        target = m_p4 + bus.branch_offset * 4;
      m_pc = target;
      m_mc = 32'h0;
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_mc = old_word;
      m_pcout = m_pc;
      m_p4 = m_pc + 4;
      m_valid = 1'b1;
      m_pc = m_pc + 4;
    end
    if (bus.imem_wr_en)
      mem_m[bus.imem_wr_addr] = bus.imem_wr_data;
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".machineCode"}, bus.machineCode, m_mc);
    chk({ctx, ".PC_out"},      bus.PC_out,      m_pcout);
    chk({ctx, ".PC_plus4"},    bus.PC_plus4,    m_p4);
    chk({ctx, ".instr_valid"}, {31'h0, bus.instr_valid}, {31'h0, m_valid});
  endtask

  task automatic cycle(input string ctx);
    @(posedge SYS_clk);
    model_step();
    #1;
    check_all(ctx);
  endtask

  task automatic idle();
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_offset = 32'h0;
    bus.jump = 1'b0; bus.jump_target = 26'h0;
    bus.imem_wr_en = 1'b0; bus.imem_wr_addr = '0; bus.imem_wr_data = 32'h0;
  endtask

  initial begin
    logic [31:0] w;
    logic [15:0] r16;
    int k;
    idle();
    SYS_reset = 1'b1;
    model_reset();
    #2;

    // Program load while held in reset.
    for (int i = 0; i < DEPTH; i++) begin
      case (i)
        0: w = W_A;
        1: w = W_B;
        2: w = W_C;
        3: w = W_D;
        default: w = $urandom;
      endcase
      bus.imem_wr_en = 1'b1;
      bus.imem_wr_addr = i[AW-1:0];
      bus.imem_wr_data = w;
      @(posedge SYS_clk);
      mem_m[i] = w;
      #1;
    end
    idle();
    check_all("reset");

    // Reset release and first fetches.
    SYS_reset = 1'b0;
    cycle("fetch1");
    chk("fetch1_A", bus.machineCode, W_A);
    cycle("fetch2");
    chk("fetch2_B", bus.machineCode, W_B);

    // Stall holds IF/ID.
    bus.stall = 1'b1;
    repeat (3) cycle("stall");
    chk("stall_held", bus.PC_out, 32'h4);
    bus.stall = 1'b0;
    cycle("unstall_C");
    chk("unstall_C", bus.machineCode, W_C);
    cycle("unstall_D");
    chk("unstall_D", bus.machineCode, W_D);

    // Jump back to 0, refetch to PC_out=8, then branch -2.
    bus.jump = 1'b1; bus.jump_target = 26'h0;
    cycle("jump0_flush");
    bus.jump = 1'b0;
    repeat (3) cycle("refetch");
    chk("refetch_pc8", bus.PC_out, 32'h8);
    bus.branch_taken = 1'b1; bus.branch_offset = 32'hFFFF_FFFE;
    cycle("branch_flush");
    chk("branch_flush_valid", {31'h0, bus.instr_valid}, 32'h0);
    bus.branch_taken = 1'b0;
    cycle("branch_target");
    chk("branch_target_pc", bus.PC_out, 32'h4);

    // Jump beats branch.
    bus.jump = 1'b1; bus.jump_target = 26'h10;
    bus.branch_taken = 1'b1; bus.branch_offset = 32'h5;
    cycle("jb_flush");
    idle();
    cycle("jb_target");
    chk("jb_target_pc", bus.PC_out, 32'h40);

    // Redirect overrides stall; redirect on a flushed slot is ignored.
    bus.stall = 1'b1; bus.jump = 1'b1; bus.jump_target = 26'h20;
    cycle("stall_redirect");
    bus.stall = 1'b0; bus.jump = 1'b0;
    bus.branch_taken = 1'b1; bus.branch_offset = 32'd100;
    cycle("ignored_redirect");
    chk("ignored_redirect_pc", bus.PC_out, 32'h80);
    idle();

    // Write to the word being fetched: old word first, new on refetch.
    k = (m_pc / 4) % DEPTH;
    bus.imem_wr_en = 1'b1; bus.imem_wr_addr = k[AW-1:0]; bus.imem_wr_data = W_NEW;
    cycle("wr_same_addr");
    idle();
    bus.jump = 1'b1; bus.jump_target = 26'(k);
    cycle("wr_refetch_flush");
    bus.jump = 1'b0;
    cycle("wr_refetch");
    chk("wr_refetch_new", bus.machineCode, W_NEW);

    // PC wraps at 2^32: jump to 0, branch to 0xFFFF_FFF8.
    bus.jump = 1'b1; bus.jump_target = 26'h0;
    cycle("wrap_j");
    bus.jump = 1'b0;
    cycle("wrap_f0");
    bus.branch_taken = 1'b1; bus.branch_offset = 32'hFFFF_FFFD;
    cycle("wrap_flush");
    bus.branch_taken = 1'b0;
    cycle("wrap_fff8");
    cycle("wrap_fffc");
    chk("wrap_plus4", bus.PC_plus4, 32'h0);
    cycle("wrap_zero");
    chk("wrap_pc0", bus.PC_out, 32'h0);

    // Randomized mix.
    for (int n = 0; n < 400; n++) begin
      bus.stall = ($urandom_range(0, 9) < 3);
      bus.jump = ($urandom_range(0, 19) == 0);
      bus.jump_target = 26'($urandom);
      bus.branch_taken = ($urandom_range(0, 9) == 0);
      r16 = 16'($urandom);
      bus.branch_offset = {{16{r16[15]}}, r16};
      bus.imem_wr_en = ($urandom_range(0, 9) == 0);
      bus.imem_wr_addr = AW'($urandom);
      bus.imem_wr_data = $urandom;
      cycle("random");
    end
    idle();

    // Async reset mid-cycle during a stall.
    bus.jump = 1'b1; bus.jump_target = 26'h0;
    cycle("pre_rst_j");
    bus.jump = 1'b0;
    cycle("pre_rst_f");
    bus.stall = 1'b1;
    cycle("pre_rst_stall");
    #3;
    SYS_reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    chk("async_reset_p4", bus.PC_plus4, 32'h4);
    @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;
    bus.stall = 1'b0;
    cycle("post_rst1");
    chk("post_rst_pc0", bus.PC_out, 32'h0);
    cycle("post_rst2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
